// File: rtl/set_bit_scanner_32bit.sv
// set_bit_scanner_32bit
// Takes one 32-bit word and emits the indices of its set bits, one per beat,
// on a valid/ready stream. An all-zero word gives a single marker beat with
// out_empty set. There is always one idle cycle between words.
// Build option: define SCANNER_MSB_FIRST_EN to emit indices from highest to
// lowest. Without it, indices come out from lowest to highest.
module set_bit_scanner_32bit (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic        out_empty,
  output logic [5:0]  out_seq
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shadow_q, shadow_d;
  logic [5:0]  cnt_q, cnt_d;

  logic        emit;
  logic        shadow_zero;
  logic        shadow_single;
  logic [4:0]  scan_idx;

  // Position of the lowest set bit; the highest position is scanned first so
  // the lowest match is the final assignment.
  function automatic logic [4:0] lsb_index(input logic [31:0] w);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (w[i]) idx = i[4:0];
    end
    return idx;
  endfunction

  // Position of the highest set bit; the lowest position is scanned first so
  // the highest match is the final assignment.
  function automatic logic [4:0] msb_index(input logic [31:0] w);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (w[i]) idx = i[4:0];
    end
    return idx;
  endfunction

  // Decode the shadow register and drive outputs; everything is forced to 0
  // outside EMIT.
  always_comb begin
    emit          = (state_q == EMIT);
    shadow_zero   = (shadow_q == 32'd0);
    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
    shadow_single = !shadow_zero && ((shadow_q & (shadow_q - 32'd1)) == 32'd0);
`ifdef SCANNER_MSB_FIRST_EN
    scan_idx      = msb_index(shadow_q);
`else
    scan_idx      = lsb_index(shadow_q);
`endif
    in_ready      = !emit;
    out_valid     = emit;
    out_index     = emit ? scan_idx : 5'd0;
    out_empty     = emit && shadow_zero;
    out_last      = emit && (shadow_zero || shadow_single);
    out_seq       = emit ? cnt_q : 6'd0;
  end

  // Next-state logic: capture a word in IDLE, then consume one set bit per
  // accepted beat in EMIT.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shadow_d = in_data;
          cnt_d    = 6'd0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            // Clearing the counter here keeps it at 31 or below.
            state_d  = IDLE;
            shadow_d = 32'd0;
            cnt_d    = 6'd0;
          end else begin
            shadow_d = shadow_q & ~(32'd1 << scan_idx);
            cnt_d    = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shadow and beat counter registers. Reset takes priority over both
  // handshakes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= 32'd0;
      cnt_q    <= 6'd0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
